alu_arbiter: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 22 ++
 rtl/alu_arbiter_alu.sv | 26 ++
 rtl/alu_arbiter.sv | 108 ++++++++++
 tb/tb_alu_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU arbiter and its datapath.
// Opcode encodings match the existing combinational ALU.
package alu_ctrl_pkg;

  localparam int DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [2:0] OP_INV = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 8-bit ALU shared by both requesters.
// All results are truncated to DW bits.
module alu_arbiter_alu
  import alu_ctrl_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  output logic [DW-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_INV:  y = ~a;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_AND:  y = a & b;
      OP_MUL:  y = a * b;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one ALU between two requesters.
// One operation in flight: IDLE -> EXEC -> RESP -> IDLE.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter bit FIRST_GRANT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [DW-1:0]    req0_a,
  input  logic [DW-1:0]    req0_b,
  input  logic [2:0]       req0_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [DW-1:0]    resp0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [DW-1:0]    req1_a,
  input  logic [DW-1:0]    req1_b,
  input  logic [2:0]       req1_op,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [DW-1:0]    resp1_data,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [2:0]    op_q;
  logic          idx_q;
  logic          rr_last;
  logic          grant;
  logic          accept;
  logic          resp_fire;
  logic [DW-1:0] alu_y;

  // Tie goes to the requester that was not served last
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~rr_last;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign resp0_valid = (state_q == RESP) && !idx_q;
  assign resp1_valid = (state_q == RESP) && idx_q;
  assign resp_fire   = idx_q ? resp1_ready : resp0_ready;

  assign busy = (state_q != IDLE);

  alu_arbiter_alu u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (alu_y)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      idx_q      <= 1'b0;
      rr_last    <= ~FIRST_GRANT;
      op_count   <= '0;
      resp0_data <= '0;
      resp1_data <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && accept) begin
        a_q   <= grant ? req1_a  : req0_a;
        b_q   <= grant ? req1_b  : req0_b;
        op_q  <= grant ? req1_op : req0_op;
        idx_q <= grant;
      end
      // The idle requester's data register keeps its last result
      if (state_q == EXEC) begin
        if (idx_q) resp1_data <= alu_y;
        else       resp0_data <= alu_y;
      end
      if (state_q == RESP && resp_fire) begin
        rr_last  <= idx_q;
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, round-robin, ALU widths,
// backpressure, reset mid-operation and counter wrap.
module tb_alu_arbiter;

  logic       clk;
  logic       reset;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic [2:0] req0_op;
  logic       resp0_valid;
  logic       resp0_ready;
  logic [7:0] resp0_data;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic [2:0] req1_op;
  logic       resp1_valid;
  logic       resp1_ready;
  logic [7:0] resp1_data;
  logic       busy;
  logic [7:0] op_count;

  int n_vec;
  int n_err;

  alu_arbiter #(.CNT_W(8), .FIRST_GRANT(1'b0)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp0_data  (resp0_data),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp1_data  (resp1_data),
    .busy        (busy),
    .op_count    (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_v0", resp0_valid, 0);
    chk("rst_v1", resp1_valid, 0);
    chk("rst_cnt", op_count, 0);
    reset = 1'b0;
    tick();
  endtask

  // Single-requester op with resp_ready raised as soon as valid is seen
  task automatic do_op(input bit w, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] op,
                       input logic [7:0] exp, input string tag);
    if (w) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    chk({tag, "_rdy"}, w ? req1_ready : req0_ready, 1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 8'hEE; req1_a = 8'hEE;
    chk({tag, "_busy"}, busy, 1);
    tick();
    chk({tag, "_vld"}, w ? resp1_valid : resp0_valid, 1);
    chk({tag, "_dat"}, w ? resp1_data : resp0_data, exp);
    if (w) resp1_ready = 1'b1;
    else   resp0_ready = 1'b1;
    tick();
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; resp0_ready = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; resp1_ready = 0;

    pulse_reset();
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_r0", req0_ready, 0);
    chk("idle_cnt", op_count, 0);

    // Single request with 2-edge latency
    req0_valid = 1; req0_a = 8'h0F; req0_b = 8'h03; req0_op = 3'b101;
    #1;
    chk("s_rdy", req0_ready, 1);
    tick();
    req0_valid = 0; req0_a = 8'hFF; req0_b = 8'hFF; req0_op = 3'b000;
    chk("s_v_exec", resp0_valid, 0);
    tick();
    chk("s_vld", resp0_valid, 1);
    chk("s_dat", resp0_data, 8'h12);
    resp0_ready = 1;
    tick();
    resp0_ready = 0;
    chk("s_cnt", op_count, 1);
    chk("s_v_off", resp0_valid, 0);

    // Tie after reset: req0 first, then req1, then req0 on the next tie
    pulse_reset();
    req0_valid = 1; req0_a = 8'h10; req0_b = 8'h20; req0_op = 3'b101;
    req1_valid = 1; req1_a = 8'h05; req1_b = 8'h07; req1_op = 3'b110;
    #1;
    chk("t1_r0", req0_ready, 1);
    chk("t1_r1", req1_ready, 0);
    tick();
    req0_valid = 0;
    chk("t1_stall", req1_ready, 0);
    tick();
    chk("t1_dat", resp0_data, 8'h30);
    chk("t1_v1", resp1_valid, 0);
    resp0_ready = 1;
    tick();
    resp0_ready = 0;
    req0_valid = 1; req0_a = 8'hAA; req0_b = 8'h0F; req0_op = 3'b010;
    #1;
    chk("t2_r1", req1_ready, 1);
    chk("t2_r0", req0_ready, 0);
    tick();
    req1_valid = 0;
    tick();
    chk("t2_dat", resp1_data, 8'hFE);
    chk("t2_hold0", resp0_data, 8'h30);
    resp1_ready = 1;
    tick();
    resp1_ready = 0;
    req1_valid = 1; req1_a = 8'hF0; req1_b = 8'h3C; req1_op = 3'b011;
    #1;
    chk("t3_r0", req0_ready, 1);
    chk("t3_r1", req1_ready, 0);
    tick();
    req0_valid = 0;
    tick();
    chk("t3_dat", resp0_data, 8'hA5);
    resp0_ready = 1;
    tick();
    resp0_ready = 0;
    #1;
    chk("t4_r1", req1_ready, 1);
    tick();
    req1_valid = 0;
    tick();
    chk("t4_dat", resp1_data, 8'h30);
    resp1_ready = 1;
    tick();
    resp1_ready = 0;
    chk("t_cnt", op_count, 4);

    // Truncation and opcode 111
    do_op(0, 8'h10, 8'h10, 3'b100, 8'h00, "mul0");
    do_op(1, 8'h0F, 8'h11, 3'b100, 8'hFF, "mulff");
    do_op(0, 8'hA5, 8'h00, 3'b000, 8'h5A, "inv");
    do_op(1, 8'hFF, 8'hFF, 3'b111, 8'h00, "nop");
    chk("nop_cnt", op_count, 8);
    do_op(0, 8'h50, 8'h0A, 3'b001, 8'h5A, "or");

    // Backpressure on resp1 while req0 waits
    req1_valid = 1; req1_a = 8'h05; req1_b = 8'h07; req1_op = 3'b110;
    tick();
    req1_valid = 0; req1_a = 8'h00;
    tick();
    req0_valid = 1; req0_a = 8'h01; req0_b = 8'h02; req0_op = 3'b101;
    for (int i = 0; i < 5; i++) begin
      chk("bp_v1", resp1_valid, 1);
      chk("bp_d1", resp1_data, 8'hFE);
      chk("bp_r0", req0_ready, 0);
      tick();
    end
    resp1_ready = 1;
    #1;
    chk("bp_r0_hs", req0_ready, 0);
    tick();
    resp1_ready = 0;
    chk("bp_r0_go", req0_ready, 1);
    tick();
    req0_valid = 0;
    tick();
    chk("bp_dat", resp0_data, 8'h03);
    resp0_ready = 1;
    tick();
    resp0_ready = 0;
    chk("bp_cnt", op_count, 11);

    // Reset while EXEC: operation dropped
    req0_valid = 1; req0_a = 8'h11; req0_b = 8'h22; req0_op = 3'b101;
    tick();
    req0_valid = 0;
    chk("rx_busy", busy, 1);
    #2;
    reset = 1;
    #1;
    chk("rx_rbusy", busy, 0);
    chk("rx_cnt", op_count, 0);
    chk("rx_d0", resp0_data, 0);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rx_nov", resp0_valid, 0);
    end
    do_op(0, 8'h0F, 8'h03, 3'b101, 8'h12, "rx_next");
    chk("rx_cnt1", op_count, 1);

    // Counter wrap at 255 -> 0
    for (int i = 1; i < 255; i++) begin
      do_op(i[0], 8'(i), 8'h01, 3'b101, 8'(i + 1), "wrap");
    end
    chk("wrap_255", op_count, 8'hFF);
    do_op(1, 8'h03, 8'h02, 3'b110, 8'h01, "wrap_last");
    chk("wrap_0", op_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
